// File: rtl/const_sweep_gen_if.sv
// Handshake/bus bundle for const_sweep_gen.
//   master : the sweep generator (drives idx, captured entry, status, checksum)
//   slave  : the environment (drives start/bounds, table value, out_ready)
interface const_sweep_gen_if #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned VAL_W = 29,
  parameter int unsigned SUM_W = 32
);
  logic             start;
  logic [IDX_W-1:0] first;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] idx;
  logic [VAL_W-1:0] val;
  logic             out_valid;
  logic             out_ready;
  logic [VAL_W-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic             busy;
  logic             done;
  logic [SUM_W-1:0] sum;

  modport master (
    input  start, first, last, val, out_ready,
    output idx, out_valid, out_data, out_idx, busy, done, sum
  );

  modport slave (
    output start, first, last, val, out_ready,
    input  idx, out_valid, out_data, out_idx, busy, done, sum
  );
endinterface

// File: rtl/const_sweep_gen.sv
// Sweeps an index range [first..last] (modulo 2^IDX_W) through an external
// combinational constant table, emits each value on a valid/ready stream and
// keeps a running checksum of the emitted values.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : const_sweep_gen_if.master
//           start/first/last in, idx out, val in (table lookup of idx),
//           out_valid/out_ready/out_data/out_idx stream, busy, done, sum.
module const_sweep_gen #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned VAL_W = 29,
  parameter int unsigned SUM_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  const_sweep_gen_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             out_valid_q, out_valid_d;
  logic [VAL_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [SUM_W-1:0] sum_q, sum_d;

  logic capture;
  logic handshake;

  // A new entry may be captured whenever the output slot is empty or is
  // being emptied in this same cycle.
  assign handshake = out_valid_q && bus.out_ready;
  assign capture   = (state_q == StRun) && (!out_valid_q || bus.out_ready);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    sum_d       = sum_q;

    // Consumed entry leaves the slot unless a capture refills it below.
    if (handshake) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          idx_d   = bus.first;
          last_d  = bus.last;
          sum_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (capture) begin
          out_data_d  = bus.val;
          out_idx_d   = idx_q;
          out_valid_d = 1'b1;
          sum_d       = sum_q + SUM_W'(bus.val);
          if (idx_q != last_q) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (handshake) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      sum_q       <= sum_d;
    end
  end

  assign bus.idx       = idx_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.sum       = sum_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);

endmodule

// File: tb/tb_const_sweep_gen.sv
// Directed, table-driven bench for const_sweep_gen.
module tb_const_sweep_gen;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned VAL_W = 29;
  localparam int unsigned SUM_W = 32;
  localparam logic [SUM_W-1:0] FullSum = 32'd536874851;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  const_sweep_gen_if #(.IDX_W(IDX_W), .VAL_W(VAL_W), .SUM_W(SUM_W)) bus ();

  const_sweep_gen #(.IDX_W(IDX_W), .VAL_W(VAL_W), .SUM_W(SUM_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Downstream constant table.
  function automatic logic [VAL_W-1:0] tbl(input logic [IDX_W-1:0] i);
    case (i)
      4'd0:    tbl = 29'd7;
      4'd1:    tbl = 29'd11;
      4'd2:    tbl = 29'd222;
      4'd3:    tbl = 29'd3456;
      4'd4:    tbl = 29'h92;
      4'd12:   tbl = 29'h1FFFFFFF;
      default: tbl = 29'(i);
    endcase
  endfunction

  assign bus.val = tbl(bus.idx);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [IDX_W-1:0] f, input logic [IDX_W-1:0] l);
    bus.first = f;
    bus.last  = l;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  logic [IDX_W-1:0] b_idx [64];
  logic [VAL_W-1:0] b_dat [64];
  int nbeats;
  int ndone;
  logic first_valid;

  // Collect beats with out_ready high until done or the budget expires.
  task automatic collect(input int budget);
    nbeats = 0;
    ndone  = 0;
    for (int c = 0; c < budget; c++) begin
      tick();
      bus.start = 1'b0;
      if (c == 0) first_valid = bus.out_valid;
      if (bus.out_valid && nbeats < 64) begin
        b_idx[nbeats] = bus.out_idx;
        b_dat[nbeats] = bus.out_data;
        nbeats++;
      end
      if (bus.done) begin
        ndone++;
        break;
      end
    end
  endtask

  typedef struct {
    logic [IDX_W-1:0] first;
    logic [IDX_W-1:0] last;
    int               cnt;
    logic [SUM_W-1:0] sum;
    int               sa_beat;
    logic [VAL_W-1:0] sa_data;
    int               sb_beat;
    logic [VAL_W-1:0] sb_data;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{4'd1,  4'd3,  3,  32'd3689, 0,  29'd11,  2,  29'd3456};
    vecs[1] = '{4'd0,  4'd15, 16, FullSum,  4,  29'h92,  12, 29'h1FFFFFFF};
    vecs[2] = '{4'd0,  4'd15, 16, FullSum,  15, 29'd15,  0,  29'd7};
    vecs[3] = '{4'd14, 4'd1,  4,  32'd47,   1,  29'd15,  2,  29'd7};
    vecs[4] = '{4'd2,  4'd2,  1,  32'd222,  0,  29'd222, 0,  29'd222};
    vecs[5] = '{4'd5,  4'd4,  16, FullSum,  11, 29'd7,   15, 29'h92};

    bus.start     = 1'b0;
    bus.first     = '0;
    bus.last      = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #1;
    check("rst_idx",       64'(bus.idx),       64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_out_idx",   64'(bus.out_idx),   64'd0);
    check("rst_sum",       64'(bus.sum),       64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);
    check("rst_done",      64'(bus.done),      64'd0);
    #11;
    rst_n = 1'b1;

    // Table-driven sweeps with out_ready held high
    for (int i = 0; i < 6; i++) begin
      do_start(vecs[i].first, vecs[i].last);
      check("start_idx",  64'(bus.idx),  64'(vecs[i].first));
      check("start_busy", 64'(bus.busy), 64'd1);
      collect(40);
      check("latency_valid", 64'(first_valid), 64'd1);
      check("beat_count",    64'(nbeats),      64'(vecs[i].cnt));
      for (int k = 0; k < nbeats && k < vecs[i].cnt; k++) begin
        logic [IDX_W-1:0] e;
        e = vecs[i].first + IDX_W'(k);
        check("beat_idx",  64'(b_idx[k]), 64'(e));
        check("beat_data", 64'(b_dat[k]), 64'(tbl(e)));
      end
      check("spot_a", 64'(b_dat[vecs[i].sa_beat]), 64'(vecs[i].sa_data));
      check("spot_b", 64'(b_dat[vecs[i].sb_beat]), 64'(vecs[i].sb_data));
      check("sum",        64'(bus.sum), 64'(vecs[i].sum));
      check("done_count", 64'(ndone),   64'd1);
      tick();
      check("done_pulse_end", 64'(bus.done), 64'd0);
      check("idle_busy",      64'(bus.busy), 64'd0);
      check("idle_sum_hold",  64'(bus.sum),  64'(vecs[i].sum));
    end

    // Single entry held under backpressure in DRAIN
    bus.out_ready = 1'b0;
    do_start(4'd2, 4'd2);
    tick();
    check("hold_valid", 64'(bus.out_valid), 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_data", 64'(bus.out_data), 64'd222);
      check("hold_idx",  64'(bus.idx),      64'd2);
      check("hold_done", 64'(bus.done),     64'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    check("hold_done_after_accept",  64'(bus.done),      64'd1);
    check("hold_valid_after_accept", 64'(bus.out_valid), 64'd0);
    tick();
    check("hold_done_drop", 64'(bus.done), 64'd0);

    // Stall in RUN: idx, data and sum freeze while out_ready is low
    do_start(4'd0, 4'd3);
    tick();
    check("stall_first_data", 64'(bus.out_data), 64'd7);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("stall_idx",     64'(bus.idx),       64'd1);
      check("stall_data",    64'(bus.out_data),  64'd7);
      check("stall_out_idx", 64'(bus.out_idx),   64'd0);
      check("stall_sum",     64'(bus.sum),       64'd7);
      check("stall_valid",   64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    collect(40);
    check("stall_beats", 64'(nbeats),   64'd3);
    check("stall_beat0", 64'(b_dat[0]), 64'd11);
    check("stall_sum_end", 64'(bus.sum), 64'd3696);
    check("stall_done",  64'(ndone),    64'd1);
    tick();

    // start during RUN is ignored
    do_start(4'd1, 4'd3);
    bus.first = 4'd9;
    bus.last  = 4'd12;
    bus.start = 1'b1;
    collect(40);
    check("ign_beats", 64'(nbeats),   64'd3);
    check("ign_idx0",  64'(b_idx[0]), 64'd1);
    check("ign_idx2",  64'(b_idx[2]), 64'd3);
    check("ign_sum",   64'(bus.sum),  64'd3689);
    check("ign_done",  64'(ndone),    64'd1);
    tick();

    // Reset mid-sweep
    do_start(4'd0, 4'd15);
    tick();
    tick();
    tick();
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_data",  64'(bus.out_data),  64'd0);
    check("mid_rst_oidx",  64'(bus.out_idx),   64'd0);
    check("mid_rst_idx",   64'(bus.idx),       64'd0);
    check("mid_rst_sum",   64'(bus.sum),       64'd0);
    check("mid_rst_busy",  64'(bus.busy),      64'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("mid_rst_done", 64'(bus.done), 64'd0);
    end
    #2;
    rst_n = 1'b1;
    do_start(4'd1, 4'd3);
    check("post_rst_busy", 64'(bus.busy), 64'd1);
    collect(40);
    check("post_rst_beats", 64'(nbeats),  64'd3);
    check("post_rst_sum",   64'(bus.sum), 64'd3689);
    check("post_rst_done",  64'(ndone),   64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
